// File: rtl/demul_pkg.sv
// Shared types and helpers for the 1-to-4 demux burst scheduler.
package demul_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    ADV  = 2'd2
  } state_t;

  typedef logic [1:0] chan_t;

  localparam int BURST_MIN = 1;
  localparam int BURST_MAX = 255;

  function automatic logic [3:0] onehot4(input chan_t sel);
    onehot4 = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/demul_rr_pick.sv
// Cyclic first-enabled-channel search starting at ptr (inclusive) or ptr+1 (exclusive).
module demul_rr_pick
  import demul_pkg::*;
(
  input  logic [1:0] ptr,
  input  logic [3:0] en,
  input  logic       incl,
  output logic [1:0] nxt_ptr,
  output logic       found
);

  logic [1:0] cand;

  // Walk from the farthest offset down so the nearest enabled channel wins;
  // the exclusive offset k+1 wraps to ptr itself at k=3.
  always_comb begin
    nxt_ptr = ptr;
    found   = 1'b0;
    cand    = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + (incl ? 2'(k) : 2'(k + 1));
      if (en[cand]) begin
        nxt_ptr = cand;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demul_sched.sv
// Round-robin burst scheduler feeding a 1-to-4 demux through one registered output stage.
module demul_sched
  import demul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       s,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ready,
  output logic             burst_done
);

  // state | meaning
  // HALT  | no channel enabled; waits for a non-zero mask
  // RUN   | accepting words for channel ptr
  // ADV   | one bubble cycle: pick next enabled channel, clear burst count

  localparam int BURST_EFF = (BURST < BURST_MIN) ? BURST_MIN :
                             (BURST > BURST_MAX) ? BURST_MAX : BURST;
  localparam logic [7:0] CNT_LAST = 8'(BURST_EFF - 1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             incl_q, incl_d;
  logic             ovalid_q, ovalid_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [1:0]       s_q, s_d;
  logic             bd_q, bd_d;

  logic [1:0] pick_ptr;
  logic       pick_found;
  logic       acc, xfer, en_any;

  demul_rr_pick u_pick (
    .ptr    (ptr_q),
    .en     (en),
    .incl   (incl_q),
    .nxt_ptr(pick_ptr),
    .found  (pick_found)
  );

  assign en_any    = |en;
  assign xfer      = ovalid_q && y_ready[s_q];
  assign din_ready = (state_q == RUN) && en[ptr_q] && (!ovalid_q || xfer);
  assign acc       = din_valid && din_ready;

  assign dout       = dout_q;
  assign s          = s_q;
  assign y_valid    = ovalid_q ? onehot4(s_q) : 4'b0000;
  assign burst_done = bd_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    incl_d   = incl_q;
    ovalid_d = ovalid_q;
    dout_d   = dout_q;
    s_d      = s_q;
    bd_d     = 1'b0;

    if (acc) begin
      dout_d   = din;
      s_d      = ptr_q;
      ovalid_d = 1'b1;
      cnt_d    = cnt_q + 8'd1;
    end else if (xfer) begin
      ovalid_d = 1'b0;
    end

    case (state_q)
      HALT: begin
        if (en_any) begin
          state_d = ADV;
          incl_d  = 1'b1;
        end
      end
      RUN: begin
        if (!en_any) begin
          state_d = HALT;
        end else if (!en[ptr_q]) begin
          state_d = ADV;
          incl_d  = 1'b0;
        end else if (acc && (cnt_q == CNT_LAST)) begin
          state_d = ADV;
          incl_d  = 1'b0;
          bd_d    = 1'b1;
        end
      end
      ADV: begin
        cnt_d = 8'd0;
        if (!en_any) begin
          state_d = HALT;
        end else begin
          state_d = RUN;
          if (pick_found) ptr_d = pick_ptr;
        end
      end
      default: state_d = HALT;
    endcase
  end

  // Undelivered output word is dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HALT;
      ptr_q    <= 2'd0;
      cnt_q    <= 8'd0;
      incl_q   <= 1'b1;
      ovalid_q <= 1'b0;
      dout_q   <= '0;
      s_q      <= 2'd0;
      bd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      incl_q   <= incl_d;
      ovalid_q <= ovalid_d;
      dout_q   <= dout_d;
      s_q      <= s_d;
      bd_q     <= bd_d;
    end
  end

endmodule

// File: tb/tb_demul_sched.sv
// Self-checking bench for demul_sched: directed vectors plus randomized scoreboard.
module tb_demul_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] en;
  logic [7:0] din;
  logic       din_valid;
  logic [3:0] y_ready;

  logic       din_ready_a, burst_done_a, din_ready_b, burst_done_b;
  logic [7:0] dout_a, dout_b;
  logic [1:0] s_a, s_b;
  logic [3:0] y_valid_a, y_valid_b;

  int checks;
  int failures;

  demul_sched #(.WIDTH(8), .BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_a), .dout(dout_a), .s(s_a), .y_valid(y_valid_a),
    .y_ready(y_ready), .burst_done(burst_done_a)
  );

  demul_sched #(.WIDTH(8), .BURST(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_b), .dout(dout_b), .s(s_b), .y_valid(y_valid_b),
    .y_ready(y_ready), .burst_done(burst_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] e);
    rst_n = 1'b0; din_valid = 1'b0; din = 8'h00; y_ready = 4'hF; en = e;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- scoreboard for randomized traffic ----------------
  bit         mon_on;
  logic [3:0] rnd_en;
  logic [9:0] sb [2][$];
  int         acc_n [2];
  bit         bd_exp [2];

  task automatic mon(input int id, input int b, input logic rdy, input logic [7:0] dq,
                     input logic [1:0] sq, input logic [3:0] yv, input logic bd);
    logic [9:0] hd;
    logic [3:0] yv_exp;
    logic [1:0] ch;
    bit xf, acc;
    int lst[$];
    chk("rnd_burst_done", {31'd0, bd}, {31'd0, bd_exp[id]});
    if (bd_exp[id]) chk("rnd_ready_adv", {31'd0, rdy}, 32'd0);
    yv_exp = 4'b0000;
    if (sb[id].size() > 0) begin
      hd = sb[id][0];
      yv_exp = 4'b0001 << hd[9:8];
      chk("rnd_dout", {24'd0, dq}, {24'd0, hd[7:0]});
      chk("rnd_s", {30'd0, sq}, {30'd0, hd[9:8]});
    end
    chk("rnd_y_valid", {28'd0, yv}, {28'd0, yv_exp});
    xf = (yv_exp & y_ready) != 4'b0000;
    if (yv_exp != 4'b0000 && !xf) chk("rnd_ready_hold", {31'd0, rdy}, 32'd0);
    acc = din_valid && rdy;
    if (xf) void'(sb[id].pop_front());
    bd_exp[id] = 1'b0;
    if (acc) begin
      for (int i = 0; i < 4; i++) if (rnd_en[i]) lst.push_back(i);
      ch = 2'(lst[(acc_n[id] / b) % lst.size()]);
      sb[id].push_back({ch, din});
      acc_n[id]++;
      if (acc_n[id] % b == 0) bd_exp[id] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon(0, 4, din_ready_a, dout_a, s_a, y_valid_a, burst_done_a);
      mon(1, 2, din_ready_b, dout_b, s_b, y_valid_b, burst_done_b);
    end
  end

  // ---------------- stream driver / delivery collector ----------------
  logic [11:0] del_q[$];
  logic [3:0]  yv_seen;

  task automatic collect(input bit sel2, input logic [7:0] first, input logic [7:0] last,
                         input int want, output int nbd);
    logic [7:0] w;
    logic [3:0] yv;
    logic [7:0] dq;
    logic rdy, bdv;
    bit acc;
    del_q.delete();
    nbd = 0; w = first; din = w; din_valid = 1'b1;
    for (int c = 0; c < 80 && del_q.size() < want; c++) begin
      @(negedge clk);
      yv  = sel2 ? y_valid_b : y_valid_a;
      dq  = sel2 ? dout_b : dout_a;
      rdy = sel2 ? din_ready_b : din_ready_a;
      bdv = sel2 ? burst_done_b : burst_done_a;
      yv_seen |= yv;
      if (bdv) nbd++;
      if ((yv & y_ready) != 4'b0000) del_q.push_back({yv, dq});
      acc = din_valid && rdy;
      tick();
      if (acc) begin
        if (w == last) din_valid = 1'b0;
        else begin
          w++;
          din = w;
        end
      end
    end
    din_valid = 1'b0;
    chk("collect_count", del_q.size(), want);
  endtask

  typedef struct {
    logic       dv;
    logic [7:0] din;
    logic [3:0] yr;
    logic       rdy;
    logic [3:0] yv;
    logic [7:0] dq;
    logic       bd;
  } vec_t;

  vec_t tbl[20];
  int   idx;
  int   nbd;
  logic [3:0] yr;

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    checks = 0; failures = 0; mon_on = 1'b0; rnd_en = 4'hF;
    rst_n = 1'b0; en = 4'hF; din = 8'hAA; din_valid = 1'b1; y_ready = 4'hF;

    // Full stream, BURST=4: four accepts then one ADV bubble per channel.
    for (int g = 0; g < 4; g++) begin
      for (int j = 0; j < 5; j++) begin
        idx = g * 5 + j;
        tbl[idx].dv  = 1'b1;
        tbl[idx].din = 8'(g * 4 + j);
        tbl[idx].yr  = 4'hF;
        tbl[idx].rdy = (j != 4);
        tbl[idx].yv  = (j == 0) ? 4'b0000 : 4'(1 << g);
        tbl[idx].dq  = 8'(g * 4 + j - 1);
        tbl[idx].bd  = (j == 4);
      end
    end

    // Reset with DIN_VALID held high
    tick(); tick();
    @(negedge clk);
    chk("rst_in_ready", din_ready_a, 0);
    chk("rst_in_yvalid", y_valid_a, 0);
    chk("rst_in_dout", dout_a, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_halt_ready", din_ready_a, 0);
    chk("rst_halt_yvalid", y_valid_a, 0);
    chk("rst_halt_s", s_a, 0);
    chk("rst_halt_bd", burst_done_a, 0);
    tick();
    @(negedge clk);
    chk("rst_adv_ready", din_ready_a, 0);
    chk("rst_adv_yvalid", y_valid_a, 0);
    chk("rst_adv_s", s_a, 0);
    tick();
    @(negedge clk);
    chk("rst_run_ready", din_ready_a, 1);
    tick();
    din_valid = 1'b0;
    @(negedge clk);
    chk("rst_first_yvalid", y_valid_a, 4'b0001);
    chk("rst_first_dout", dout_a, 8'hAA);
    chk("rst_first_s", s_a, 0);

    // Table-driven full stream
    do_reset(4'hF); tick(); tick();
    for (int i = 0; i < 20; i++) begin
      din_valid = tbl[i].dv; din = tbl[i].din; y_ready = tbl[i].yr;
      @(negedge clk);
      chk("fs_ready", din_ready_a, tbl[i].rdy);
      chk("fs_yvalid", y_valid_a, tbl[i].yv);
      chk("fs_burst_done", burst_done_a, tbl[i].bd);
      if (tbl[i].yv != 4'b0000) chk("fs_dout", dout_a, tbl[i].dq);
      tick();
    end
    din_valid = 1'b0;

    // Backpressure on channel 0
    do_reset(4'hF); tick(); tick();
    din = 8'h00; din_valid = 1'b1;
    @(negedge clk);
    chk("bp_ready0", din_ready_a, 1);
    tick();
    din = 8'h01; y_ready = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_yvalid", y_valid_a, 4'b0001);
      chk("bp_hold_dout", dout_a, 8'h00);
      chk("bp_hold_ready", din_ready_a, 0);
      tick();
    end
    y_ready = 4'hF;
    @(negedge clk);
    chk("bp_release_ready", din_ready_a, 1);
    chk("bp_release_dout", dout_a, 8'h00);
    tick();
    din_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_yvalid", y_valid_a, 4'b0001);
    chk("bp_next_dout", dout_a, 8'h01);

    // Sparse mask on the BURST=2 instance
    do_reset(4'b0101); tick(); tick();
    yv_seen = 4'b0000;
    collect(1'b1, 8'h10, 8'h17, 8, nbd);
    for (int k = 0; k < 8 && k < del_q.size(); k++) begin
      chk("sp_chan", del_q[k][11:8], ((k / 2) % 2 == 0) ? 4'b0001 : 4'b0100);
      chk("sp_data", del_q[k][7:0], 8'(8'h10 + k));
    end
    chk("sp_unused_chan", yv_seen & 4'b1010, 0);
    chk("sp_burst_done_n", nbd, 4);

    // Mid-burst disable of channel 0 with its sink stalled
    do_reset(4'hF); tick(); tick();
    din = 8'h20; din_valid = 1'b1;
    tick();
    din = 8'h21;
    tick();
    din = 8'h22; y_ready = 4'b1110; en = 4'b1110;
    @(negedge clk);
    chk("mb_run_ready", din_ready_a, 0);
    chk("mb_run_yvalid", y_valid_a, 4'b0001);
    chk("mb_run_dout", dout_a, 8'h21);
    chk("mb_run_bd", burst_done_a, 0);
    tick();
    @(negedge clk);
    chk("mb_adv_ready", din_ready_a, 0);
    chk("mb_adv_bd", burst_done_a, 0);
    tick();
    @(negedge clk);
    chk("mb_stall_ready", din_ready_a, 0);
    chk("mb_stall_yvalid", y_valid_a, 4'b0001);
    tick();
    y_ready = 4'hF;
    collect(1'b0, 8'h22, 8'h25, 5, nbd);
    for (int k = 0; k < 5 && k < del_q.size(); k++) begin
      chk("mb_chan", del_q[k][11:8], (k == 0) ? 4'b0001 : 4'b0010);
      chk("mb_data", del_q[k][7:0], 8'(8'h21 + k));
    end
    chk("mb_burst_done_n", nbd, 1);

    // Asynchronous reset while a word waits on channel 1
    do_reset(4'b0010); tick(); tick();
    din = 8'h5A; din_valid = 1'b1; y_ready = 4'b1101;
    tick();
    din_valid = 1'b0;
    @(negedge clk);
    chk("ar_before_yvalid", y_valid_a, 4'b0010);
    chk("ar_before_dout", dout_a, 8'h5A);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_async_yvalid", y_valid_a, 0);
    chk("ar_async_dout", dout_a, 0);
    tick();
    rst_n = 1'b1; y_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ar_dropped_yvalid", y_valid_a, 0);
      tick();
    end

    // Randomized traffic against the scoreboard, constant mask per segment
    for (int seg = 0; seg < 6; seg++) begin
      rnd_en = 4'($urandom_range(1, 15));
      do_reset(rnd_en);
      for (int id = 0; id < 2; id++) begin
        sb[id].delete();
        acc_n[id] = 0;
        bd_exp[id] = 1'b0;
      end
      mon_on = 1'b1;
      for (int c = 0; c < 200; c++) begin
        din = 8'($urandom);
        din_valid = ($urandom_range(0, 9) < 7);
        for (int b = 0; b < 4; b++) yr[b] = ($urandom_range(0, 3) != 0);
        y_ready = yr;
        tick();
      end
      din_valid = 1'b0; y_ready = 4'hF;
      repeat (4) tick();
      mon_on = 1'b0;
      chk("rnd_drained_a", sb[0].size(), 0);
      chk("rnd_drained_b", sb[1].size(), 0);
      chk("rnd_progress_a", acc_n[0] > 20, 1);
      chk("rnd_progress_b", acc_n[1] > 20, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
